button_events: RTL

Classifies the debounced push-button level produced by the debounce stage into discrete user events: press/release strobes, single click, double click and long press. It sits directly downstream of the debouncer and upstream of the workshop's control logic, e.g. a mode FSM or counter, which consumes single-cycle event pulses instead of a raw level.

---
 rtl/button_events_pkg.sv | 19 +
 rtl/edge_detect.sv | 21 ++
 rtl/button_events.sv | 111 +++++++++++
 3 files changed

// File: rtl/button_events_pkg.sv
// rtl/button_events_pkg.sv - shared types and sizing helper for button_events
// FSM state encoding and the width of the shared dwell counter.
package button_events_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESSED1,
    WAIT_GAP,
    PRESSED2,
    LONG_HELD
  } state_t;

  function automatic int cnt_width(input int long_cycles, input int gap_cycles);
    int max_cycles;
    max_cycles = (long_cycles > gap_cycles) ? long_cycles : gap_cycles;
    return $clog2(max_cycles + 1);
  endfunction

endpackage

// File: rtl/edge_detect.sv
// rtl/edge_detect.sv - registers a level and flags its rising and falling edges
// Delay register clears to 0, so a level already high at reset release reads as a rise.
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic din_i,
  output logic rise_o,
  output logic fall_o
);

  logic din_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) din_q <= 1'b0;
    else       din_q <= din_i;
  end

  assign rise_o = din_i & ~din_q;
  assign fall_o = ~din_i & din_q;

endmodule

// File: rtl/button_events.sv
// rtl/button_events.sv - turns a debounced button level into press/release/click/long events
// One dwell counter is shared by every state; all outputs are registered strobes.
module button_events
  import button_events_pkg::*;
#(
  parameter int LONG_CYCLES = 1000,
  parameter int GAP_CYCLES  = 300
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_click,
  output logic double_click,
  output logic long_press,
  output logic held
);

  localparam int CW = cnt_width(LONG_CYCLES, GAP_CYCLES);
  // The sample that enters a state is the first of its run, so thresholds sit two below N.
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 2);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 2);
  localparam logic [CW-1:0] CNT_MAX   = '1;

  logic          rise, fall;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          short_d, double_d, long_d;
  logic          press_q, release_q, short_q, double_q, long_q, held_q;

  edge_detect u_edge (
    .clk   (clk),
    .reset (reset),
    .din_i (btn),
    .rise_o(rise),
    .fall_o(fall)
  );

  // Edges are checked before thresholds so a coincident edge wins.
  always_comb begin
    state_d  = state_q;
    short_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    case (state_q)
      IDLE: if (rise) state_d = PRESSED1;
      PRESSED1: begin
        if (fall) begin
          state_d = WAIT_GAP;
        end else if (btn && cnt_q == LONG_LAST) begin
          state_d = LONG_HELD;
          long_d  = 1'b1;
        end
      end
      WAIT_GAP: begin
        if (rise) begin
          state_d = PRESSED2;
        end else if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          short_d = 1'b1;
        end
      end
      PRESSED2: begin
        if (fall) begin
          state_d  = IDLE;
          double_d = 1'b1;
        end else if (btn && cnt_q == LONG_LAST) begin
          state_d = LONG_HELD;
          long_d  = 1'b1;
        end
      end
      LONG_HELD: if (fall) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d != state_q)  cnt_d = '0;
    else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
    else                     cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      short_q   <= 1'b0;
      double_q  <= 1'b0;
      long_q    <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= rise;
      release_q <= fall;
      short_q   <= short_d;
      double_q  <= double_d;
      long_q    <= long_d;
      held_q    <= (state_d == LONG_HELD);
    end
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign short_click   = short_q;
  assign double_click  = double_q;
  assign long_press    = long_q;
  assign held          = held_q;

endmodule
